// File: rtl/armm_pkg.sv
// Shared definitions for the ARMM hazard/forwarding controller.
//   ARMM_RADDR_W     : register-index width used by the in-flight entry
//   SEL_RF           : operand-select code meaning "take the register file"
//   inflight_entry_t : one tracked instruction in the EXE..WB shadow pipeline
//   hz_state_e       : branch-flush FSM states
package armm_pkg;

  localparam int ARMM_RADDR_W = 4;
  localparam int SEL_RF       = 0;

  typedef struct packed {
    logic                    valid;
    logic                    we;
    logic                    load;
    logic [ARMM_RADDR_W-1:0] dest;
    logic [ARMM_RADDR_W-1:0] src1;
    logic [ARMM_RADDR_W-1:0] src2;
    logic                    use1;
    logic                    use2;
  } inflight_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

endpackage

// File: rtl/armm_inflight_pipe.sv
// Shadow shift register of in-flight instructions, stage 0 = EXE,
// stage NSTG-1 = WB. Stage 0 loads in_entry when push is high, otherwise a
// bubble (all-zero entry, so its use bits can never produce a match).
//   clk, rst  : clock, asynchronous active-high reset
//   push      : accept in_entry into EXE this edge
//   in_entry  : ID-stage fields
//   stage_o   : registered entries, one per stage
module armm_inflight_pipe
  import armm_pkg::*;
#(
  parameter int NSTG = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  inflight_entry_t in_entry,
  output inflight_entry_t stage_o [NSTG]
);

  inflight_entry_t stage_q [NSTG];
  inflight_entry_t stage_d [NSTG];

  always_comb begin
    stage_d[0] = push ? in_entry : '0;
    for (int k = 1; k < NSTG; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/armm_hazard_ctrl.sv
// ARMM hazard/forwarding controller: tracks in-flight writers, produces the
// IF/ID stall, the branch flush and the EXE operand-select codes.
// Optional feature macro: ARMM_PERF_CNT_EN enables the stall/flush counters;
// without it perf_stall_cnt/perf_flush_cnt are tied to 0.
//   clk, rst                 : clock, asynchronous active-high reset
//   forward_en               : 1 = forwarding, 0 = stall-only interlock
//   id_*                     : instruction currently in ID
//   ex_branch_taken          : branch in EXE resolved taken
//   stall, flush             : pipeline control (flush has priority)
//   sel_src1/sel_src2        : 0 = regfile, k = forward from stage k
//   ex_valid                 : EXE holds a real instruction
//   perf_stall_cnt/flush_cnt : performance counters
module armm_hazard_ctrl
  import armm_pkg::*;
#(
  parameter int  RADDR_W    = ARMM_RADDR_W,
  parameter int  FWD_STAGES = 2,
  parameter int  LOAD_LAT   = 1,
  parameter int  BR_FLUSH   = 1,
  localparam int NSTG       = FWD_STAGES + 1,
  localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               forward_en,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_src1,
  input  logic [RADDR_W-1:0] id_src2,
  input  logic               id_use1,
  input  logic               id_use2,
  input  logic [RADDR_W-1:0] id_dest,
  input  logic               id_we,
  input  logic               id_load,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush,
  output logic [SEL_W-1:0]   sel_src1,
  output logic [SEL_W-1:0]   sel_src2,
  output logic               ex_valid,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
);

  localparam int FCNT_W = $clog2(BR_FLUSH + 1);

  // The entry layout is fixed by the package register-index width.
  if (RADDR_W != ARMM_RADDR_W) begin : g_width_check
    $error("armm_hazard_ctrl: RADDR_W must equal armm_pkg::ARMM_RADDR_W");
  end

  inflight_entry_t stg [NSTG];
  inflight_entry_t id_entry;
  logic            push;
  logic            stall_raw;
  logic            flush_raw;
  logic [NSTG-1:0] id_hit;
  logic            unused_fields;
  hz_state_e       state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  function automatic logic match(inflight_entry_t e, logic [ARMM_RADDR_W-1:0] s,
                                 logic use_bit);
    return e.valid & e.we & (e.dest == s) & use_bit;
  endfunction

  always_comb begin
    id_entry       = '0;
    id_entry.valid = 1'b1;
    id_entry.we    = id_we;
    id_entry.load  = id_load;
    id_entry.dest  = id_dest;
    id_entry.src1  = id_src1;
    id_entry.src2  = id_src2;
    id_entry.use1  = id_use1;
    id_entry.use2  = id_use2;
  end

  assign push = id_valid & ~stall & ~flush;

  armm_inflight_pipe #(.NSTG(NSTG)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .in_entry (id_entry),
    .stage_o  (stg)
  );

  assign ex_valid = stg[0].valid;

  // Forwarding: scan oldest to youngest so the youngest match wins. A load
  // is not a legal source until its data has arrived (stage >= 1+LOAD_LAT).
  always_comb begin
    sel_src1 = SEL_W'(SEL_RF);
    sel_src2 = SEL_W'(SEL_RF);
    if (forward_en) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (!(stg[k].load && (k < 1 + LOAD_LAT))) begin
          if (match(stg[k], stg[0].src1, stg[0].use1)) sel_src1 = SEL_W'(k);
          if (match(stg[k], stg[0].src2, stg[0].use2)) sel_src2 = SEL_W'(k);
        end
      end
    end
  end

  // ID-stage interlock. WB is excluded: the regfile writes through.
  always_comb begin
    id_hit    = '0;
    stall_raw = 1'b0;
    for (int j = 0; j < NSTG - 1; j++) begin
      id_hit[j] = match(stg[j], id_src1, id_use1) | match(stg[j], id_src2, id_use2);
      if (forward_en) begin
        if (id_hit[j] && stg[j].load && (j < LOAD_LAT)) stall_raw = 1'b1;
      end else if (id_hit[j]) begin
        stall_raw = 1'b1;
      end
    end
    stall_raw = stall_raw & id_valid;
  end

  // Source fields beyond EXE are carried only for completeness of the entry.
  always_comb begin
    unused_fields = id_hit[NSTG-1];
    for (int k = 1; k < NSTG; k++) begin
      unused_fields = unused_fields ^ (^{stg[k].src1, stg[k].src2, stg[k].use1, stg[k].use2});
    end
  end

  // Branch flush FSM: RUN flushes the cycle the branch resolves; FLUSH covers
  // the remaining BR_FLUSH-1 cycles and ignores ex_branch_taken (EXE bubble).
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    flush_raw = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          flush_raw = 1'b1;
          if (BR_FLUSH > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_W'(BR_FLUSH - 1);
          end
        end
      end
      ST_FLUSH: begin
        flush_raw = 1'b1;
        fcnt_d    = fcnt_q - 1'b1;
        if (fcnt_q == FCNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Outputs are forced low while reset is held so they clear immediately.
  assign flush = ~rst & flush_raw;
  assign stall = ~rst & stall_raw & ~flush_raw;

`ifdef ARMM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        br_accept;

  assign br_accept = (state_q == ST_RUN) & ex_branch_taken;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, br_accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_armm_hazard_ctrl.sv
// Self-checking bench for armm_hazard_ctrl (FWD_STAGES=2, LOAD_LAT=1,
// BR_FLUSH=2). Expected per-cycle outputs are queued when stimulus is driven
// and popped/compared at the following falling edge.
module tb_armm_hazard_ctrl;

`ifdef ARMM_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic        id_valid;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        id_use1, id_use2, id_we, id_load;
  logic        ex_branch_taken;
  logic        stall, flush, ex_valid;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    st;
    int    fl;
    int    s1;
    int    s2;
    int    ev;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  armm_hazard_ctrl #(
    .RADDR_W    (4),
    .FWD_STAGES (2),
    .LOAD_LAT   (1),
    .BR_FLUSH   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .forward_en      (forward_en),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_use1         (id_use1),
    .id_use2         (id_use2),
    .id_dest         (id_dest),
    .id_we           (id_we),
    .id_load         (id_load),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .sel_src1        (sel_src1),
    .sel_src2        (sel_src2),
    .ex_valid        (ex_valid),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );

  task automatic chk(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic set_id(bit v, int s1, bit u1, int s2, bit u2, int d, bit we, bit ld);
    id_valid = v;
    id_src1  = 4'(s1);
    id_use1  = u1;
    id_src2  = 4'(s2);
    id_use2  = u2;
    id_dest  = 4'(d);
    id_we    = we;
    id_load  = ld;
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp_pop();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".stall"},    int'(stall),    e.st);
    chk({e.tag, ".flush"},    int'(flush),    e.fl);
    chk({e.tag, ".sel1"},     int'(sel_src1), e.s1);
    chk({e.tag, ".sel2"},     int'(sel_src2), e.s2);
    chk({e.tag, ".ex_valid"}, int'(ex_valid), e.ev);
  endtask

  // Queue the expectation for the inputs just driven, compare at negedge.
  task automatic expect_cyc(string tag, int st, int fl, int s1, int s2, int ev);
    exp_t e;
    e.tag = tag; e.st = st; e.fl = fl; e.s1 = s1; e.s2 = s2; e.ev = ev;
    sb.push_back(e);
    @(negedge clk);
    cmp_pop();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string tag, int st, int fl, int s1, int s2, int ev);
    expect_cyc(tag, st, fl, s1, s2, ev);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    forward_en = 1'b1;
    ex_branch_taken = 1'b1;
    set_id(1, 1, 1, 1, 1, 1, 1, 1);
    #1;
    expect_cyc("reset", 0, 0, 0, 0, 0);
    chk("reset.pstall", int'(perf_stall_cnt), 0);
    chk("reset.pflush", int'(perf_flush_cnt), 0);
    tick();
    rst = 1'b0;
    ex_branch_taken = 1'b0;
    idle_id();

    // ALU result forwarded from MEM
    set_id(1, 5, 0, 6, 0, 1, 1, 0); step("t1c0", 0, 0, 0, 0, 0);
    set_id(1, 1, 1, 2, 0, 7, 1, 0); step("t1c1", 0, 0, 0, 0, 1);
    idle_id();                      step("t1c2", 0, 0, 1, 0, 1);
    idle_id();                      step("t1c3", 0, 0, 0, 0, 0);

    // Two writers of r4: youngest wins; unused source never forwards
    set_id(1, 0, 0, 0, 0, 4, 1, 0); step("t5c0", 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 4, 1, 0); step("t5c1", 0, 0, 0, 0, 1);
    set_id(1, 4, 1, 4, 0, 8, 0, 0); step("t5c2", 0, 0, 0, 0, 1);
    set_id(1, 4, 0, 4, 1, 8, 0, 0); step("t5c3", 0, 0, 1, 0, 1);
    idle_id();                      step("t5c4", 0, 0, 0, 2, 1);

    // Load-use: one stall, then forwarded from WB
    set_id(1, 0, 0, 0, 0, 2, 1, 1); step("t2c0", 0, 0, 0, 0, 0);
    set_id(1, 2, 1, 0, 0, 9, 0, 0); step("t2c1", 1, 0, 0, 0, 1);
                                    step("t2c2", 0, 0, 0, 0, 0);
    idle_id();                      step("t2c3", 0, 0, 2, 0, 1);

    // Taken branch with load-use pending: flush wins for BR_FLUSH cycles
    set_id(1, 0, 0, 0, 0, 2, 1, 1); step("t4c0", 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 2, 1, 9, 0, 0);
    ex_branch_taken = 1'b1;         step("t4c1", 0, 1, 0, 0, 1);
                                    step("t4c2", 0, 1, 0, 0, 0);
    ex_branch_taken = 1'b0;
    idle_id();                      step("t4c3", 0, 0, 0, 0, 0);
    chk("t4.pflush", int'(perf_flush_cnt), PERF * 1);
    chk("t4.pstall", int'(perf_stall_cnt), PERF * 1);

    // Stall-only mode: consumer waits until producer reaches WB
    forward_en = 1'b0;
    set_id(1, 0, 0, 0, 0, 3, 1, 0); step("t3c0", 0, 0, 0, 0, 0);
    set_id(1, 3, 1, 3, 1, 9, 0, 0); step("t3c1", 1, 0, 0, 0, 1);
                                    step("t3c2", 1, 0, 0, 0, 0);
                                    step("t3c3", 0, 0, 0, 0, 0);
    idle_id();                      step("t3c4", 0, 0, 0, 0, 1);

    // Reset asserted in the middle of a load-use stall
    forward_en = 1'b1;
    set_id(1, 0, 0, 0, 0, 5, 1, 1); step("t6c0", 0, 0, 0, 0, 0);
    set_id(1, 5, 1, 0, 0, 9, 0, 0); expect_cyc("t6c1", 1, 0, 0, 0, 1);
    chk("t6.pstall_pre", int'(perf_stall_cnt), PERF * 3);
    chk("t6.pflush_pre", int'(perf_flush_cnt), PERF * 1);
    #1;
    rst = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    chk("t6.rst.stall",    int'(stall),          0);
    chk("t6.rst.flush",    int'(flush),          0);
    chk("t6.rst.sel1",     int'(sel_src1),       0);
    chk("t6.rst.sel2",     int'(sel_src2),       0);
    chk("t6.rst.ex_valid", int'(ex_valid),       0);
    chk("t6.rst.pstall",   int'(perf_stall_cnt), 0);
    chk("t6.rst.pflush",   int'(perf_flush_cnt), 0);
    tick();
    rst = 1'b0;
    ex_branch_taken = 1'b0;
    step("t6post", 0, 0, 0, 0, 0);
    idle_id();
    step("t6post2", 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
